// File: rtl/shifter_pipe.sv
// ============================================================================
// shifter_pipe
// ----------------------------------------------------------------------------
// Parametrised, pipelined barrel shifter. Each pipeline stage implements one
// log2 layer of the shifter: stage k shifts or rotates its operand by 2^k
// positions when bit k of the shift count is set. Otherwise the operand passes
// through unchanged. The pipeline is elastic, so a stage can load in the same
// cycle that its contents move downstream. This lets it sustain one result per
// clock with no bubbles.
//
// Operations (in_op):
//   000 ROL  rotate left
//   001 SLL  logical shift left (zero fill)
//   010 ROR  rotate right
//   011 SRL  logical shift right (zero fill)
//   100 SRA  arithmetic shift right when SHIFTER_PIPE_SRA_EN is defined,
//            otherwise decoded as SRL
//   101..111 decoded as SRL
//
// Optional feature macro: SHIFTER_PIPE_SRA_EN
//   When defined, op 100 performs an arithmetic right shift, replicating the
//   operand MSB at every layer. When undefined, no SRA logic is built.
//
// Parameters:
//   WIDTH  operand width (power of two, >= 4)
//   LOG2W  log2(WIDTH); this is the count width and the number of stages
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset, empties the pipeline
//   in_valid   an operation is presented on in_data/in_cnt/in_op
//   in_ready   stage 0 can take an operation this cycle
//   in_data    operand
//   in_cnt     shift/rotate amount, 0..WIDTH-1
//   in_op      operation select (see table above)
//   out_valid  a result is presented on out_data
//   out_ready  the consumer takes the result this cycle
//   out_data   shifted/rotated result (don't-care while out_valid is low)
// ============================================================================
module shifter_pipe #(
    parameter int WIDTH = 16,
    parameter int LOG2W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LOG2W-1:0] in_cnt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [2:0] {
        OP_ROL = 3'b000,
        OP_SLL = 3'b001,
        OP_ROR = 3'b010,
        OP_SRL = 3'b011,
        OP_SRA = 3'b100
    } op_e;

    // One shifter layer. The caller passes the layer's shift distance as a
    // constant, so each instance reduces to fixed wiring plus a small mux.
    // The rotations OR the shifted operand with its complementary wrap-around
    // part. This stays exact for the WIDTH/2 layer, where both halves swap.
    function automatic logic [WIDTH-1:0] apply_layer(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic             en,
        input int               s
    );
        logic [WIDTH-1:0] r;
        r = d;
        if (en) begin
            case (op)
                OP_ROL:  r = (d << s) | (d >> (WIDTH - s));
                OP_SLL:  r = d << s;
                OP_ROR:  r = (d >> s) | (d << (WIDTH - s));
                OP_SRL:  r = d >> s;
`ifdef SHIFTER_PIPE_SRA_EN
                OP_SRA:  r = $unsigned($signed(d) >>> s);
`endif
                default: r = d >> s;
            endcase
        end
        return r;
    endfunction

    // Flattened views of the per-stage registers. The generate loop below
    // drives them, and the handshake logic and the next stage read them.
    logic [LOG2W-1:0] v_vec;
    logic [LOG2W-1:0] adv;
    logic [WIDTH-1:0] data_vec [LOG2W];
    logic [LOG2W-1:0] cnt_vec  [LOG2W];
    logic [2:0]       op_vec   [LOG2W];

    // Advance chain. Stage k may hand its contents on when the next stage is
    // empty, or when the next stage is itself advancing. The last stage
    // advances exactly when the consumer is ready. This walks from the output
    // back toward the input, so no path exists from in_valid to out_valid.
    always_comb begin
        adv = '0;
        adv[LOG2W-1] = out_ready;
        for (int k = LOG2W - 2; k >= 0; k--) begin
            adv[k] = ~v_vec[k+1] | adv[k+1];
        end
    end

    assign in_ready  = ~v_vec[0] | adv[0];
    assign out_valid = v_vec[LOG2W-1];
    assign out_data  = data_vec[LOG2W-1];

    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        logic             vin;
        logic [WIDTH-1:0] din;
        logic [LOG2W-1:0] cin;
        logic [2:0]       oin;
        logic             load;

        logic             v_q;
        logic [WIDTH-1:0] data_q;
        logic [LOG2W-1:0] cnt_q;
        logic [2:0]       op_q;

        if (k == 0) begin : g_src_in
            assign vin = in_valid;
            assign din = in_data;
            assign cin = in_cnt;
            assign oin = in_op;
        end else begin : g_src_prev
            assign vin = v_vec[k-1];
            assign din = data_vec[k-1];
            assign cin = cnt_vec[k-1];
            assign oin = op_vec[k-1];
        end

        // A stage takes new contents when it is empty or when its current
        // contents leave in this same cycle. Data, count and op are written
        // only when a valid operation arrives, so an empty stage keeps its
        // old values instead of toggling.
        assign load = ~v_q | adv[k];

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q    <= 1'b0;
                data_q <= '0;
                cnt_q  <= '0;
                op_q   <= '0;
            end else if (load) begin
                v_q <= vin;
                if (vin) begin
                    data_q <= apply_layer(din, oin, cin[k], 1 << k);
                    cnt_q  <= cin;
                    op_q   <= oin;
                end
            end
        end

        assign v_vec[k]    = v_q;
        assign data_vec[k] = data_q;
        assign cnt_vec[k]  = cnt_q;
        assign op_vec[k]   = op_q;
    end

    // The last stage keeps its count and op only to keep every stage
    // register set identical. No logic downstream uses them.
    logic unused_tail;
    assign unused_tail = ^{cnt_vec[LOG2W-1], op_vec[LOG2W-1]};

endmodule
